// File: rtl/dll_ack_nak_ctrl.sv
// dll_ack_nak_ctrl
// ACK/NAK protocol controller for the data link layer. Tracks AckD_SEQ from
// decoded ACK/NAK DLLPs, tells the replay buffer what to purge and when to
// replay, runs the replay timer and the REPLAY_NUM counter, and escalates to
// a link retrain once the allowed number of replays has been used up.
//
// Interface semantics: there is no backpressure anywhere. dllp_valid,
// tlp_sent, replay_done and retrain_ack are one-cycle strobes sampled on the
// rising edge of clk. purge_valid, replay_req and dllp_err are one-cycle
// strobes that appear the cycle after the causing input. purge_count and
// replay_seq are only meaningful while their strobe is high. tx_block and
// retrain_req are levels.
module dll_ack_nak_ctrl #(
    parameter int SEQ_W          = 12,
    parameter int TIMER_LIMIT    = 711,
    parameter int REPLAY_NUM_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dllp_valid,
    input  logic [1:0]       dllp_type,
    input  logic [SEQ_W-1:0] dllp_seq,
    input  logic             dllp_crc_ok,
    input  logic             tlp_sent,
    input  logic [SEQ_W-1:0] next_tx_seq,
    input  logic             replay_done,
    input  logic             retrain_ack,
    output logic             purge_valid,
    output logic [SEQ_W-1:0] purge_count,
    output logic             replay_req,
    output logic [SEQ_W-1:0] replay_seq,
    output logic             tx_block,
    output logic [SEQ_W-1:0] acked_seq,
    output logic [1:0]       replay_num,
    output logic             retrain_req,
    output logic             dllp_err,
    output logic [1:0]       state_dbg
);

    localparam int               TMR_W    = $clog2(TIMER_LIMIT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMER_LIMIT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);
    localparam logic [1:0]       RN_MAX   = 2'(REPLAY_NUM_MAX);

    localparam logic [1:0] TYPE_ACK = 2'b01;
    localparam logic [1:0] TYPE_NAK = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REPLAY_WAIT = 2'd1,
        ST_RETRAIN     = 2'd2
    } state_t;

    state_t           state_q;
    logic [TMR_W-1:0] tmr_cnt;
    logic             tmr_run;

    logic [SEQ_W-1:0] outstanding;
    logic [SEQ_W-1:0] ack_delta;
    logic [SEQ_W-1:0] remaining;
    logic [SEQ_W-1:0] start_seq;
    logic             type_ok;
    logic             accepted;
    logic             in_range;
    logic             progress;
    logic             timer_due;
    logic             expire;
    logic             nak_replay;
    logic             replay_start;
    logic [1:0]       rn_base;
    logic [1:0]       rn_next;

    assign state_dbg = state_q;

    // Decode the incoming DLLP against AckD_SEQ and decide whether this cycle
    // purges, replays, flags an error, or lets the replay timer fire.
    always_comb begin
        outstanding  = next_tx_seq - acked_seq - SEQ_ONE;
        ack_delta    = dllp_seq - acked_seq;
        type_ok      = (dllp_type == TYPE_ACK) || (dllp_type == TYPE_NAK);
        // DLLPs are ignored entirely while waiting for the retrain to finish.
        accepted     = dllp_valid && dllp_crc_ok && type_ok && (state_q != ST_RETRAIN);
        in_range     = (ack_delta <= outstanding);
        progress     = accepted && in_range && (ack_delta != '0);
        remaining    = progress ? (outstanding - ack_delta) : outstanding;
        // The counter parks at its last value if expiry is pre-empted by a
        // DLLP, so the expiry is retried on the next quiet cycle.
        timer_due    = tmr_run && (state_q == ST_IDLE) && (outstanding != '0) &&
                       (tmr_cnt >= TMR_LAST);
        expire       = timer_due && !accepted;
        nak_replay   = accepted && in_range && (dllp_type == TYPE_NAK) && (state_q == ST_IDLE);
        replay_start = nak_replay || expire;
        start_seq    = nak_replay ? (dllp_seq + SEQ_ONE) : (acked_seq + SEQ_ONE);
        // A purge clears REPLAY_NUM before a NAK's replay counts against it.
        rn_base      = progress ? 2'd0 : replay_num;
        rn_next      = (rn_base == 2'b11) ? rn_base : (rn_base + 2'd1);
    end

    // Protocol state machine, AckD_SEQ, replay timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acked_seq   <= '1;
            replay_num  <= 2'd0;
            tmr_cnt     <= '0;
            tmr_run     <= 1'b0;
            purge_valid <= 1'b0;
            purge_count <= '0;
            replay_req  <= 1'b0;
            replay_seq  <= '0;
            tx_block    <= 1'b0;
            retrain_req <= 1'b0;
            dllp_err    <= 1'b0;
        end else begin
            purge_valid <= progress;
            dllp_err    <= accepted && !in_range;
            replay_req  <= 1'b0;

            if (progress) begin
                purge_count <= ack_delta;
                acked_seq   <= dllp_seq;
                replay_num  <= 2'd0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (replay_start) begin
                        tmr_cnt  <= '0;
                        tmr_run  <= 1'b0;
                        tx_block <= 1'b1;
                        if (rn_base == RN_MAX) begin
                            replay_num  <= 2'd0;
                            retrain_req <= 1'b1;
                            state_q     <= ST_RETRAIN;
                        end else begin
                            replay_num <= rn_next;
                            replay_req <= 1'b1;
                            replay_seq <= start_seq;
                            state_q    <= ST_REPLAY_WAIT;
                        end
                    end else if (progress) begin
                        // Forward progress restarts the timer, and stops it when
                        // nothing is left unacknowledged (this beats tlp_sent).
                        tmr_cnt <= '0;
                        tmr_run <= (remaining != '0);
                    end else if (tmr_run) begin
                        if ((outstanding != '0) && (tmr_cnt < TMR_LAST)) begin
                            tmr_cnt <= tmr_cnt + TMR_ONE;
                        end
                    end else if (tlp_sent) begin
                        tmr_run <= 1'b1;
                        tmr_cnt <= '0;
                    end
                end

                ST_REPLAY_WAIT: begin
                    tmr_cnt <= '0;
                    if (replay_done) begin
                        state_q  <= ST_IDLE;
                        tx_block <= 1'b0;
                        tmr_run  <= (remaining != '0);
                    end else if (progress) begin
                        tmr_run <= (remaining != '0);
                    end
                end

                ST_RETRAIN: begin
                    tmr_cnt <= '0;
                    tmr_run <= 1'b0;
                    if (retrain_ack) begin
                        retrain_req <= 1'b0;
                        replay_req  <= 1'b1;
                        replay_seq  <= acked_seq + SEQ_ONE;
                        state_q     <= ST_REPLAY_WAIT;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
